// File: rtl/multi_channel_pattern_sequencer.sv
// N-channel pattern sequencer: each channel walks header -> order list -> pattern -> note,
// sharing one synchronous song ROM through a pipelined round-robin read arbiter.
module multi_channel_pattern_sequencer #(
  parameter int NUM_CH     = 4,
  parameter int ROM_ADDR_W = 10,
  parameter int ORDER_BASE = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic                    i_stop,
  input  logic [NUM_CH-1:0]       i_note_stb,
  output logic [NUM_CH-1:0]       o_note_valid,
  output logic [6*NUM_CH-1:0]     o_note_pitch,
  output logic [5*NUM_CH-1:0]     o_note_len,
  output logic [4*NUM_CH-1:0]     o_note_instrument,
  output logic [NUM_CH-1:0]       o_done,
  output logic [NUM_CH-1:0]       o_underrun,
  output logic [ROM_ADDR_W-1:0]   o_rom_addr,
  output logic                    o_rom_rd,
  input  logic [15:0]             i_rom_data
);

  localparam int LEN_W = 16 - ROM_ADDR_W;
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_ORD, S_WAIT, S_PAT, S_ADV, S_DONE
  } state_t;

  state_t                r_state    [NUM_CH];
  logic [5:0]            r_last     [NUM_CH];
  logic [5:0]            r_rep_idx  [NUM_CH];
  logic [5:0]            r_ord_idx  [NUM_CH];
  logic [ROM_ADDR_W-1:0] r_pat_addr [NUM_CH];
  logic [LEN_W-1:0]      r_pat_len  [NUM_CH];
  logic [LEN_W-1:0]      r_cnt      [NUM_CH];
  logic [5:0]            r_pitch    [NUM_CH];
  logic [4:0]            r_len      [NUM_CH];
  logic [3:0]            r_inst     [NUM_CH];
  logic [NUM_CH-1:0]     r_rep_en;
  logic [NUM_CH-1:0]     r_pend;
  logic [NUM_CH-1:0]     r_valid;
  logic [NUM_CH-1:0]     r_done;
  logic [NUM_CH-1:0]     r_underrun;
  logic [CH_W-1:0]       r_ptr;

  logic [NUM_CH-1:0]     w_req;
  logic [ROM_ADDR_W-1:0] w_ch_addr [NUM_CH];
  logic                  w_gnt_valid;
  logic [CH_W-1:0]       w_gnt_ch;
  logic                  w_hold;

  // Control pulses and reset suppress new grants so nothing is read that would be discarded.
  assign w_hold = i_rst | i_stop | i_start;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    w_req = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_ch_addr[c] = r_pat_addr[c];
      w_req[c]     = !w_hold && !r_pend[c] &&
                     (r_state[c] == S_HDR || r_state[c] == S_ORD || r_state[c] == S_PAT);
      case (r_state[c])
        S_HDR:   w_ch_addr[c] = ROM_ADDR_W'(c);
        S_ORD:   w_ch_addr[c] = ROM_ADDR_W'(ORDER_BASE + 64 * c) + ROM_ADDR_W'(r_ord_idx[c]);
        default: w_ch_addr[c] = r_pat_addr[c];
      endcase
    end
  end

  // Round-robin search: walk a doubled channel range starting at the pointer.
  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt_ch    = '0;
    for (int k = 0; k < 2 * NUM_CH; k++) begin
      if (!w_gnt_valid && k >= int'(r_ptr) && k < int'(r_ptr) + NUM_CH && w_req[k % NUM_CH]) begin
        w_gnt_valid = 1'b1;
        w_gnt_ch    = CH_W'(k % NUM_CH);
      end
    end
  end

  assign o_rom_rd   = w_gnt_valid;
  assign o_rom_addr = w_gnt_valid ? w_ch_addr[w_gnt_ch] : '0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr      <= '0;
      r_rep_en   <= '0;
      r_pend     <= '0;
      r_valid    <= '0;
      r_done     <= '0;
      r_underrun <= '0;
      // NOTE: these per-channel arrays are plain flops, not RAM, so resetting them is legal and cheap.
      for (int c = 0; c < NUM_CH; c++) begin
        r_state[c]    <= S_IDLE;
        r_last[c]     <= '0;
        r_rep_idx[c]  <= '0;
        r_ord_idx[c]  <= '0;
        r_pat_addr[c] <= '0;
        r_pat_len[c]  <= '0;
        r_cnt[c]      <= '0;
        r_pitch[c]    <= '0;
        r_len[c]      <= '0;
        r_inst[c]     <= '0;
      end
    end else begin
      if (w_gnt_valid) begin
        r_ptr <= (int'(w_gnt_ch) == NUM_CH - 1) ? '0 : w_gnt_ch + 1'b1;
      end
      r_valid <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        if (i_stop) begin
          r_state[c] <= S_IDLE;
          r_pend[c]  <= 1'b0;
          r_done[c]  <= 1'b0;
        end else if (i_start) begin
          r_state[c]    <= S_HDR;
          r_pend[c]     <= 1'b0;
          r_done[c]     <= 1'b0;
          r_underrun[c] <= 1'b0;
        end else begin
          // A channel's read is outstanding for exactly the cycle after its grant.
          r_pend[c] <= w_gnt_valid && (int'(w_gnt_ch) == c);
          if (i_note_stb[c] && r_state[c] != S_WAIT && r_state[c] != S_DONE &&
              r_state[c] != S_IDLE) begin
            r_underrun[c] <= 1'b1;
          end
          case (r_state[c])
            S_IDLE: ;
            S_HDR: begin
              if (r_pend[c]) begin
                r_last[c]    <= i_rom_data[5:0];
                r_rep_idx[c] <= i_rom_data[11:6];
                r_rep_en[c]  <= i_rom_data[12];
                r_ord_idx[c] <= '0;
                r_state[c]   <= S_ORD;
              end
            end
            S_ORD: begin
              if (r_pend[c]) begin
                r_pat_addr[c] <= i_rom_data[ROM_ADDR_W-1:0];
                r_pat_len[c]  <= i_rom_data[15:ROM_ADDR_W];
                r_cnt[c]      <= '0;
                r_state[c]    <= (i_rom_data[15:ROM_ADDR_W] == '0) ? S_ADV : S_WAIT;
              end
            end
            S_WAIT: begin
              if (i_note_stb[c]) r_state[c] <= S_PAT;
            end
            S_PAT: begin
              if (r_pend[c]) begin
                r_pitch[c]    <= i_rom_data[5:0];
                r_len[c]      <= i_rom_data[10:6];
                r_inst[c]     <= i_rom_data[14:11];
                r_valid[c]    <= 1'b1;
                r_cnt[c]      <= r_cnt[c] + 1'b1;
                r_pat_addr[c] <= r_pat_addr[c] + 1'b1;
                r_state[c]    <= ((r_cnt[c] + 1'b1) == r_pat_len[c]) ? S_ADV : S_WAIT;
              end
            end
            S_ADV: begin
              if (r_ord_idx[c] != r_last[c]) begin
                r_ord_idx[c] <= r_ord_idx[c] + 1'b1;
                r_state[c]   <= S_ORD;
              end else if (r_rep_en[c]) begin
                r_ord_idx[c] <= r_rep_idx[c];
                r_state[c]   <= S_ORD;
              end else begin
                r_done[c]  <= 1'b1;
                r_state[c] <= S_DONE;
              end
            end
            S_DONE: ;
            default: r_state[c] <= S_IDLE;
          endcase
        end
      end
    end
  end

  always_comb begin
    o_note_pitch      = '0;
    o_note_len        = '0;
    o_note_instrument = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      o_note_pitch[6*c +: 6]      = r_pitch[c];
      o_note_len[5*c +: 5]        = r_len[c];
      o_note_instrument[4*c +: 4] = r_inst[c];
    end
  end

  assign o_note_valid = r_valid;
  assign o_done       = r_done;
  assign o_underrun   = r_underrun;

endmodule

// File: tb/tb_multi_channel_pattern_sequencer.sv
// Scoreboard bench: a song-level model predicts each channel's note stream from the ROM image;
// a negedge monitor pops and compares whenever a channel presents o_note_valid.
module tb_multi_channel_pattern_sequencer;

  localparam int NUM_CH = 4;
  localparam int AW     = 10;
  localparam int OB     = 16;
  localparam int ROM_SZ = 1 << AW;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  start = 1'b0;
  logic                  stop = 1'b0;
  logic [NUM_CH-1:0]     stb = '0;
  logic [NUM_CH-1:0]     note_valid;
  logic [6*NUM_CH-1:0]   note_pitch;
  logic [5*NUM_CH-1:0]   note_len;
  logic [4*NUM_CH-1:0]   note_inst;
  logic [NUM_CH-1:0]     done;
  logic [NUM_CH-1:0]     underrun;
  logic [AW-1:0]         rom_addr;
  logic                  rom_rd;
  logic [15:0]           rom_data;

  multi_channel_pattern_sequencer #(.NUM_CH(NUM_CH), .ROM_ADDR_W(AW), .ORDER_BASE(OB)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop), .i_note_stb(stb),
    .o_note_valid(note_valid), .o_note_pitch(note_pitch), .o_note_len(note_len),
    .o_note_instrument(note_inst), .o_done(done), .o_underrun(underrun),
    .o_rom_addr(rom_addr), .o_rom_rd(rom_rd), .i_rom_data(rom_data)
  );

  always #5 clk = ~clk;

  logic [15:0] rom [ROM_SZ];
  always @(posedge clk) rom_data <= rom[rom_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int pitch;
    int len;
    int inst;
    int stb_cyc;
    int max_lat;
  } exp_t;

  exp_t sb_q [NUM_CH][$];
  int   n_total = 0;
  int   n_bad = 0;
  int   vcount [NUM_CH];
  int   last_act [NUM_CH];
  int   prev_f [NUM_CH];
  int   rd_count = 0;
  logic rst_prev = 1'b1;

  // Song-level model cursor: order index, note position inside that entry, finished flag.
  int m_idx [NUM_CH];
  int m_pos [NUM_CH];
  bit m_done [NUM_CH];

  task automatic check(input string name, input int ch, input int act, input int exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s ch%0d: got %0d expected %0d (cycle %0d)", name, ch, act, exp, cyc);
    end
  endtask

  function automatic int cur_fields(input int c);
    return int'({note_inst[4*c +: 4], note_len[5*c +: 5], note_pitch[6*c +: 6]});
  endfunction

  // Returns the ROM address of the channel's next note, or -1 once a non-repeating song is over.
  function automatic int model_next(input int c);
    logic [15:0] h, o;
    int last, rep, len, a;
    bit en;
    h = rom[c];
    last = int'(h[5:0]);
    rep = int'(h[11:6]);
    en = h[12];
    for (int g = 0; g < 400; g++) begin
      if (m_done[c]) return -1;
      o = rom[OB + 64 * c + m_idx[c]];
      len = int'(o[15:AW]);
      if (m_pos[c] < len) begin
        a = (int'(o[AW-1:0]) + m_pos[c]) % ROM_SZ;
        m_pos[c]++;
        return a;
      end
      m_pos[c] = 0;
      if (m_idx[c] != last) m_idx[c] = (m_idx[c] + 1) % 64;
      else if (en) m_idx[c] = rep;
      else m_done[c] = 1'b1;
    end
    return -2;
  endfunction

  function automatic bit model_finished(input int c);
    int si, sp, a;
    bit sd;
    si = m_idx[c];
    sp = m_pos[c];
    sd = m_done[c];
    a = model_next(c);
    m_idx[c] = si;
    m_pos[c] = sp;
    m_done[c] = sd;
    return a == -1;
  endfunction

  function automatic logic [15:0] ord_word(input int len, input int addr);
    return 16'((len << AW) | (addr % ROM_SZ));
  endfunction

  always @(negedge clk) begin
    if (!(rst || rst_prev)) begin
      if (rom_rd) rd_count++;
      for (int c = 0; c < NUM_CH; c++) begin
        if (note_valid[c]) begin
          exp_t e;
          int lat, elat;
          vcount[c]++;
          last_act[c] = cyc;
          check("note_expected", c, int'(sb_q[c].size() > 0), 1);
          if (sb_q[c].size() > 0) begin
            e = sb_q[c].pop_front();
            check("pitch", c, int'(note_pitch[6*c +: 6]), e.pitch);
            check("len", c, int'(note_len[5*c +: 5]), e.len);
            check("instrument", c, int'(note_inst[4*c +: 4]), e.inst);
            lat = cyc - e.stb_cyc;
            elat = (lat < 3) ? 3 : ((lat > e.max_lat) ? e.max_lat : lat);
            check("latency", c, lat, elat);
          end
        end else begin
          check("fields_hold", c, cur_fields(c), prev_f[c]);
        end
      end
    end
    for (int c = 0; c < NUM_CH; c++) prev_f[c] = cur_fields(c);
    rst_prev = rst;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_idx[c] = 0;
      m_pos[c] = 0;
      m_done[c] = 1'b0;
      sb_q[c].delete();
      last_act[c] = cyc;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    model_reset();
    tick(1);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    model_reset();
    tick(20);
  endtask

  // Strobe with a model-predicted note for each channel in the mask.
  task automatic strobe(input logic [NUM_CH-1:0] mask, input int max_lat);
    exp_t e;
    int a;
    logic [15:0] w;
    for (int c = 0; c < NUM_CH; c++) begin
      if (mask[c]) begin
        last_act[c] = cyc;
        a = model_next(c);
        if (a >= 0) begin
          w = rom[a];
          e.pitch = int'(w[5:0]);
          e.len = int'(w[10:6]);
          e.inst = int'(w[14:11]);
          e.stb_cyc = cyc;
          e.max_lat = max_lat;
          sb_q[c].push_back(e);
        end
      end
    end
    stb = mask;
    tick(1);
    stb = '0;
  endtask

  // Strobe that the DUT is expected to drop or ignore.
  task automatic raw_strobe(input logic [NUM_CH-1:0] mask);
    stb = mask;
    tick(1);
    stb = '0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < ROM_SZ; i++) rom[i] = 16'($urandom);
    for (int c = 0; c < NUM_CH; c++) begin
      rom[c] = 16'h0000;
      rom[OB + 64 * c] = 16'h0000;
    end
  endtask

  task automatic random_song();
    int last, rep, en, len;
    clear_rom();
    for (int c = 0; c < NUM_CH; c++) begin
      last = $urandom_range(0, 3);
      en = $urandom_range(0, 1);
      rep = $urandom_range(0, last);
      rom[c] = 16'((en << 12) | (rep << 6) | last);
      for (int i = 0; i <= last; i++) begin
        len = (i == last) ? $urandom_range(1, 3) : $urandom_range(0, 3);
        rom[OB + 64 * c + i] = ord_word(len, 'h280 + 32 * c + 8 * i);
      end
    end
  endtask

  task automatic check_drained(input string name);
    for (int c = 0; c < NUM_CH; c++) check(name, c, sb_q[c].size(), 0);
  endtask

  initial begin
    int v0, rd0;
    logic [NUM_CH-1:0] mask;
    for (int c = 0; c < NUM_CH; c++) begin
      vcount[c] = 0;
      prev_f[c] = 0;
    end
    clear_rom();
    do_reset();

    // Reset state
    check("rst_valid", 0, int'(note_valid), 0);
    check("rst_done", 0, int'(done), 0);
    check("rst_underrun", 0, int'(underrun), 0);
    check("rst_rom_rd", 0, int'(rom_rd), 0);
    check("rst_rom_addr", 0, int'(rom_addr), 0);
    check("rst_fields", 0, int'(note_pitch) + int'(note_len) + int'(note_inst), 0);

    // Basic two-entry song on channel 0, exact uncontended latency
    clear_rom();
    rom[0] = 16'h0001;
    rom[OB] = ord_word(2, 'h100);
    rom[OB + 1] = ord_word(1, 'h110);
    do_start();
    for (int k = 0; k < 3; k++) begin
      strobe(4'b0001, 3);
      tick(9);
    end
    tick(5);
    check("song_done", 0, int'(done[0]), 1);
    v0 = vcount[0];
    strobe(4'b0001, 3);
    tick(10);
    check("done_strobe_ignored", 0, vcount[0] - v0, 0);
    check("done_no_underrun", 0, int'(underrun[0]), 0);
    check_drained("basic_pending");

    // Repeating song: order 0,1,2,1,2,... never done
    clear_rom();
    rom[0] = 16'h1000 | 16'(1 << 6) | 16'd2;
    rom[OB] = ord_word(1, 'h140);
    rom[OB + 1] = ord_word(2, 'h150);
    rom[OB + 2] = ord_word(1, 'h160);
    do_start();
    for (int k = 0; k < 9; k++) begin
      strobe(4'b0001, 3);
      tick(11);
    end
    check("repeat_not_done", 0, int'(done[0]), 0);
    check_drained("repeat_pending");

    // All channels strobed together: one grant per cycle, latencies 3..6
    clear_rom();
    for (int c = 0; c < NUM_CH; c++) rom[OB + 64 * c] = ord_word(2, 'h300 + 16 * c);
    do_start();
    strobe(4'b1111, 6);
    tick(12);
    strobe(4'b1111, 6);
    tick(12);
    check("all_done", 0, int'(done), 15);
    check_drained("contention_pending");

    // Zero-length middle entry skipped; pattern address wraps past the top of ROM
    clear_rom();
    rom[0] = 16'h0002;
    rom[OB] = ord_word(1, 'h180);
    rom[OB + 1] = ord_word(0, 'h190);
    rom[OB + 2] = ord_word(2, 'h3FF);
    do_start();
    for (int k = 0; k < 3; k++) begin
      strobe(4'b0001, 3);
      tick(14);
    end
    check("zero_len_done", 0, int'(done[0]), 1);
    check_drained("zero_len_pending");

    // Underrun during PAT, then stop mid-pattern and restart
    clear_rom();
    rom[OB] = ord_word(3, 'h120);
    do_start();
    strobe(4'b0001, 3);
    raw_strobe(4'b0001);
    tick(10);
    check("underrun_set", 0, int'(underrun[0]), 1);
    strobe(4'b0001, 3);
    tick(10);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    tick(3);
    check("stop_done_clear", 0, int'(done[0]), 0);
    check("stop_keeps_underrun", 0, int'(underrun[0]), 1);
    do_start();
    check("start_clears_underrun", 0, int'(underrun[0]), 0);
    strobe(4'b0001, 3);
    tick(10);
    check_drained("restart_pending");

    // Start and stop together: everything stays idle, no ROM traffic
    do_reset();
    rd0 = rd_count;
    start = 1'b1;
    stop = 1'b1;
    tick(1);
    start = 1'b0;
    stop = 1'b0;
    tick(5);
    raw_strobe(4'b1111);
    tick(15);
    check("start_stop_no_reads", 0, rd_count - rd0, 0);
    check("idle_no_underrun", 0, int'(underrun), 0);

    // Reset while a granted read's data is in flight: the note never appears
    clear_rom();
    rom[OB] = ord_word(3, 'h120);
    do_start();
    rd0 = rd_count;
    v0 = vcount[0];
    raw_strobe(4'b0001);
    tick(1);
    check("read_was_granted", 0, rd_count - rd0, 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    model_reset();
    tick(10);
    check("rst_discards_note", 0, vcount[0] - v0, 0);
    check("rst_clears_fields", 0, int'(note_pitch[5:0]), 0);

    // Randomized songs with randomized strobes on all channels
    for (int round = 0; round < 3; round++) begin
      random_song();
      do_start();
      for (int t = 0; t < 800; t++) begin
        mask = '0;
        for (int c = 0; c < NUM_CH; c++) begin
          if (sb_q[c].size() == 0 && cyc - last_act[c] >= 40 && $urandom_range(0, 3) == 0)
            mask[c] = 1'b1;
        end
        if (mask != '0) strobe(mask, 3 + NUM_CH - 1);
        else tick(1);
      end
      tick(40);
      check_drained("random_pending");
      check("random_underrun", round, int'(underrun), 0);
      for (int c = 0; c < NUM_CH; c++) check("random_done", c, int'(done[c]), int'(model_finished(c)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
